// File: rtl/ccfilt_mc.sv
// Multi-channel second-order comb: two cascaded first differences per channel, then a
// rounding right shift with signed saturation. Results emerge 3 cycles after each sample.
module ccfilt_mc #(
    parameter int dw    = 36,
    parameter int outw  = 20,
    parameter int nchan = 8,
    parameter int cw    = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            sr_val,
    input  logic [dw-1:0]   sr_out,
    input  logic            sr_sync,
    input  logic [3:0]      shift,
    output logic [outw-1:0] result,
    output logic [cw-1:0]   result_chan,
    output logic            strobe,
    output logic            sat,
    output logic            sync_err
);

    localparam logic [cw-1:0]      last_ch = cw'(nchan - 1);
    localparam logic signed [dw:0] sat_max = {{(dw-outw+2){1'b0}}, {(outw-1){1'b1}}};
    localparam logic signed [dw:0] sat_min = {{(dw-outw+2){1'b1}}, {(outw-1){1'b0}}};

    // Sized to the full index range so any channel tag addresses a real entry.
    logic [dw-1:0] h1 [2**cw];
    logic [dw-1:0] h2 [2**cw];

    logic [cw-1:0]   ch_q, ch_d, tag;
    logic [1:0]      warm_q, warm_d;
    logic            sync_err_q, sync_err_d;

    logic            v1_q, v1_d, live1_q, live1_d;
    logic [cw-1:0]   ch1_q, ch1_d;
    logic [dw-1:0]   d1_q, d1_d;

    logic            v2_q, v2_d, live2_q, live2_d;
    logic [cw-1:0]   ch2_q, ch2_d;
    logic [dw-1:0]   d2_q, d2_d;

    logic [outw-1:0] result_q, result_d;
    logic [cw-1:0]   result_chan_q, result_chan_d;
    logic            strobe_q, strobe_d, sat_q, sat_d;

    logic [dw:0]        rnd;
    logic signed [dw:0] sum, scaled;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        ch_d       = ch_q;
        warm_d     = warm_q;
        sync_err_d = 1'b0;
        tag        = ch_q;
        if (sr_val) begin
            if (sr_sync) begin
                tag        = '0;
                ch_d       = (nchan == 1) ? '0 : cw'(1);
                sync_err_d = (ch_q != '0);
            end else begin
                ch_d = (ch_q == last_ch) ? '0 : ch_q + 1'b1;
            end
            if (sync_err_d) begin
                warm_d = '0;
            end else if (tag == last_ch && warm_q != 2'd3) begin
                warm_d = warm_q + 2'd1;
            end
        end
        // A sample is live only if two full frames of history preceded it.
        v1_d    = sr_val;
        live1_d = sr_val && !sync_err_d && warm_q[1];
        ch1_d   = tag;
        d1_d    = sr_out - h1[tag];
    end

    always_comb begin
        v2_d    = v1_q;
        live2_d = live1_q;
        ch2_d   = ch1_q;
        d2_d    = d1_q - h2[ch1_q];
    end

    always_comb begin
        rnd    = (shift == 4'd0) ? '0 : ((dw+1)'(1) << (shift - 4'd1));
        sum    = {d2_q[dw-1], d2_q} + rnd;
        scaled = sum >>> shift;

        result_d      = result_q;
        result_chan_d = result_chan_q;
        strobe_d      = v2_q && live2_q;
        sat_d         = 1'b0;
        if (strobe_d) begin
            result_chan_d = ch2_q;
            if (scaled > sat_max) begin
                result_d = sat_max[outw-1:0];
                sat_d    = 1'b1;
            end else if (scaled < sat_min) begin
                result_d = sat_min[outw-1:0];
                sat_d    = 1'b1;
            end else begin
                result_d = scaled[outw-1:0];
            end
        end
    end

    // NOTE: history is left out of reset on purpose; warm-up masks its contents and it can map to RAM.
    always_ff @(posedge clk) begin
        if (sr_val) h1[tag] <= sr_out;
        if (v1_q)   h2[ch1_q] <= d1_q;
    end

    // NOTE: non-blocking assignments make every flop sample the pre-edge value of its _d.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch_q          <= '0;
            warm_q        <= '0;
            sync_err_q    <= 1'b0;
            v1_q          <= 1'b0;
            live1_q       <= 1'b0;
            ch1_q         <= '0;
            d1_q          <= '0;
            v2_q          <= 1'b0;
            live2_q       <= 1'b0;
            ch2_q         <= '0;
            d2_q          <= '0;
            result_q      <= '0;
            result_chan_q <= '0;
            strobe_q      <= 1'b0;
            sat_q         <= 1'b0;
        end else begin
            ch_q          <= ch_d;
            warm_q        <= warm_d;
            sync_err_q    <= sync_err_d;
            v1_q          <= v1_d;
            live1_q       <= live1_d;
            ch1_q         <= ch1_d;
            d1_q          <= d1_d;
            v2_q          <= v2_d;
            live2_q       <= live2_d;
            ch2_q         <= ch2_d;
            d2_q          <= d2_d;
            result_q      <= result_d;
            result_chan_q <= result_chan_d;
            strobe_q      <= strobe_d;
            sat_q         <= sat_d;
        end
    end

    assign result      = result_q;
    assign result_chan = result_chan_q;
    assign strobe      = strobe_q;
    assign sat         = sat_q;
    assign sync_err    = sync_err_q;

endmodule

// File: doc/ccfilt_mc.md
Name: ccfilt_mc

Overview:
- Multi-channel successor to the single-channel comb filter.
- Takes a time-multiplexed stream of double-integrator outputs, one sample per channel per frame.
- Per channel: applies a second-order comb (two cascaded first differences), then programmable right shift with round-half-up and signed saturation.
- Emits a channel-tagged result strobe for storage. Sits between the integrator shift-register readout and the result buffer/DPRAM writer.

Parameters:
- dw, 36: input sample width, two's complement; comb arithmetic is modulo 2^dw.
- outw, 20: output result width, signed; must be less than or equal to dw.
- nchan, 8: channels per frame; 1 to 2^cw.
- cw, 3: channel index width.

Ports:
- clk, input, 1: single clock, all logic on rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- sr_val, input, 1: input sample valid; may be high every cycle.
- sr_out, input, dw: input sample, qualified by sr_val.
- sr_sync, input, 1: marks channel-0 sample of a frame; only meaningful with sr_val.
- shift, input, 4: right-shift amount 0..15; semi-static; sampled per sample in stage 3.
- result, output, outw: filtered, scaled, saturated value.
- result_chan, output, cw: channel index of result.
- strobe, output, 1: result valid, one cycle per accepted sample after warm-up.
- sat, output, 1: high with strobe when this result was clipped.
- sync_err, output, 1: one-cycle pulse on frame misalignment.

Behaviour:
- Reset (async assert, sync release): result=0, result_chan=0, strobe=0, sat=0, sync_err=0, channel counter=0, warm-up count=0, pipeline valids=0.
- History arrays h1[nchan] and h2[nchan] need no reset; their contents are masked by warm-up.
- Channel counter ch:
  - Advances only on sr_val; wraps nchan-1 -> 0.
  - If sr_val and sr_sync are both high, the sample is tagged channel 0 and ch becomes 1 (0 if nchan=1).
  - If ch != 0 at that moment, pulse sync_err the next cycle and clear warm-up count to 0.
- Warm-up:
  - 2-bit saturating frame count; increments when a channel nchan-1 sample is accepted.
  - strobe is suppressed (sat also 0) while count < 2.
  - The pipeline still updates history during warm-up.
- Pipeline, latency exactly 3 cycles from sr_val to strobe, full throughput:
  - S1: d1 = sr_out - h1[ch] (dw bits, wrap); h1[ch] <= sr_out; register d1, ch, valid.
  - S2: d2 = d1 - h2[ch1] (wrap); h2[ch1] <= d1; register d2, ch, valid.
  - S3: if shift > 0, add 2^(shift-1) in dw+1 bits; arithmetic shift right by shift; saturate to [-2^(outw-1), 2^(outw-1)-1]; set sat if clipped; register result, result_chan, strobe.
- Same channel on consecutive cycles (nchan=1) must read the value written the previous cycle; writes are registered before the next read, so no bypass is needed beyond that.
- Gaps in sr_val stall nothing: valid bubbles propagate, and result holds its last value when strobe=0.
- shift changing mid-frame takes effect for samples reaching S3 after the change; no glitch requirement beyond that.
- rst_n asserted mid-frame discards in-flight samples: no strobe may appear after reset release until 2 full frames have completed.

Test Plan:
- nchan=4, constant sr_out=1000 all channels, shift=0 -> no strobe during the first 2 frames; thereafter result=0, sat=0, result_chan cycles 0,1,2,3 with strobe 3 cycles after each sr_val.
- Ramp per channel of slope k=ch*5 (integrator of a constant, i.e. double-integrated input is quadratic: x[n]=k*n*(n+1)/2), shift=0 -> after warm-up result equals k for each channel.
- Input d2=7 with shift=1 -> result=4 (round half up). d2=-7 with shift=1 -> result=-3. shift=0 -> result passed unchanged.
- d2 = 2^21 with outw=20, shift=0 -> result=524287, sat=1. d2 = -2^21 -> result=-524288, sat=1.
- sr_sync asserted on a channel-2 sample -> sync_err pulses once, sample is tagged channel 0, strobe is suppressed for the next 2 frames, then realigned outputs resume.
- Back-to-back sr_val for 64 cycles across the sr_out wrap from 2^35-1 to -2^35 -> correct modular comb output, no strobe drop. Then assert rst_n low mid-frame -> all outputs 0 immediately, warm-up restarts.
